hc595_serial_tx: RTL and testbench

- Serial transmitter for the digital-tube driver.
- Takes a parallel segment/digit-select word and shifts it out to a daisy-chained 74HC595 pair (DS/SHCP/STCP/OE_n).
- Optional on-the-fly bit-order reversal (rvs_en) allows LSB-first or MSB-first chain wiring.
- Sits between the tube scan controller (word producer) and the board pins.

---
 rtl/hc595_serial_tx.sv | 130 +++++++++++++
 tb/tb_hc595_serial_tx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hc595_serial_tx.sv
// hc595_serial_tx
//   Serial transmitter for a daisy-chained 74HC595 pair driving the digital tube.
//   A parallel word is captured on start (optionally bit-reversed), shifted out
//   MSB of the shift register first on ds with a divided shift clock on shcp.
//   It is then latched with one stcp pulse. oe_n is released after the first
//   completed latch, so the tube never shows the 595's power-up garbage.
//
// Ports
//   clk, rst_n  : system clock, asynchronous active-low reset
//   start       : transfer request, sampled only when not busy (IDLE/DONE)
//   rvs_en      : 1 = data[0] goes out first, 0 = data[DATA_W-1] first
//   data        : word to transmit, captured on an accepted start
//   busy        : transfer in progress
//   done        : one-cycle pulse after the latch completes
//   ds/shcp/stcp/oe_n : 595 serial data, shift clock, latch clock, output enable
module hc595_serial_tx #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              rvs_en,
    input  logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic              ds,
    output logic              shcp,
    output logic              stcp,
    output logic              oe_n
);

    localparam int BIT_W = $clog2(DATA_W);
    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE} state_t;

    state_t            state;
    logic [DATA_W-1:0] sreg;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [DATA_W-1:0] data_rev;
    logic [DATA_W-1:0] load_word;

    always_comb begin
        data_rev = '0;
        for (int i = 0; i < DATA_W; i++) data_rev[i] = data[DATA_W-1-i];
    end

    assign load_word = rvs_en ? data_rev : data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sreg    <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ds      <= 1'b0;
            shcp    <= 1'b0;
            stcp    <= 1'b0;
            oe_n    <= 1'b1;
        end else begin
            case (state)
                // DONE accepts start exactly like IDLE so transfers can run back-to-back.
                IDLE, DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        sreg    <= load_word;
                        // ds is registered, so present the first bit on the accepting edge.
                        ds      <= load_word[DATA_W-1];
                        bit_cnt <= '0;
                        div_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT_LO;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT_LO: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        shcp    <= 1'b1;
                        state   <= SHIFT_HI;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        shcp    <= 1'b0;
                        sreg    <= {sreg[DATA_W-2:0], 1'b0};
                        if (bit_cnt == BIT_LAST) begin
                            // Last bit: hold the counter rather than wrap it.
                            ds    <= 1'b0;
                            stcp  <= 1'b1;
                            state <= LATCH;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            // Next bit goes out on the falling shcp edge.
                            ds      <= sreg[DATA_W-2];
                            state   <= SHIFT_LO;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                LATCH: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        stcp    <= 1'b0;
                        oe_n    <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hc595_serial_tx.sv
// tb_hc595_serial_tx
//   Directed bench for hc595_serial_tx at DATA_W=16, CLK_DIV=2. A cycle-level
//   reference model computes the expected pin waveform from the transfer's
//   start cycle and word. Every cycle is checked against it, and hand-computed
//   literals pin the bit order, latency and pulse counts.
module tb_hc595_serial_tx;
    localparam int DW      = 16;
    localparam int CD      = 2;
    localparam int SH_T    = 2 * CD * DW;   // last shifting cycle offset
    localparam int LAT_T   = SH_T + CD;     // last latch cycle offset
    localparam int DONE_T  = LAT_T + 1;     // done cycle offset

    logic          clk = 1'b0, rst_n = 1'b1, start = 1'b0, rvs_en = 1'b0;
    logic [DW-1:0] data = '0;
    logic          busy, done, ds, shcp, stcp, oe_n;

    hc595_serial_tx #(.DATA_W(DW), .CLK_DIV(CD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rvs_en(rvs_en), .data(data),
        .busy(busy), .done(done), .ds(ds), .shcp(shcp), .stcp(stcp), .oe_n(oe_n)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rev16(input logic [DW-1:0] w);
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) r[i] = w[DW-1-i];
        return r;
    endfunction

    // Reference model: one transfer at a time, described by its start cycle.
    bit            m_act = 0, m_oe = 0;
    int            cyc = 0, c0 = 0;
    logic [DW-1:0] m_w = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act = 0;
            m_oe  = 0;
        end else begin
            int t;
            t = cyc - c0;
            if (m_act && t == LAT_T) m_oe = 1;
            if (m_act && t == DONE_T) m_act = 0;
            if (!m_act && start) begin
                m_act = 1;
                c0    = cyc;
                m_w   = rvs_en ? rev16(data) : data;
            end
            cyc++;
        end
    end

    bit chk_en = 0;
    int ndone = 0, stcp_hi = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            logic [5:0] e;   // {busy, done, ds, shcp, stcp, oe_n}
            int t;
            e = 6'b000001;
            if (rst_n) begin
                t = cyc - c0;
                if (m_oe) e[0] = 1'b0;
                if (m_act) begin
                    if (t >= 1 && t <= SH_T) begin
                        e[5] = 1'b1;
                        e[3] = m_w[DW-1-(t-1)/(2*CD)];
                        e[2] = ((t - 1) % (2 * CD)) >= CD;
                    end else if (t > SH_T && t <= LAT_T) begin
                        e[5] = 1'b1;
                        e[1] = 1'b1;
                    end else if (t == DONE_T) begin
                        e[4] = 1'b1;
                    end
                end
            end
            chk("cycle pins", {26'd0, busy, done, ds, shcp, stcp, oe_n}, {26'd0, e});
            if (done) ndone++;
            if (stcp) stcp_hi++;
        end
    end

    // Pin-level capture: what the 595 chain would actually shift in.
    logic [DW-1:0] rx = '0;
    int nedge = 0, npulse = 0;
    always @(posedge shcp) begin
        rx = {rx[DW-2:0], ds};
        nedge++;
    end
    always @(posedge stcp) npulse++;

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 300);
        if (!done) chk("done timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic run_xfer(input logic [DW-1:0] d, input logic r, input logic [DW-1:0] exp,
                            input string nm);
        int n, p0, h0;
        @(negedge clk); #1;
        data = d; rvs_en = r; start = 1'b1;
        nedge = 0; rx = '0; p0 = npulse; h0 = stcp_hi;
        @(negedge clk); #1;
        start = 1'b0;
        wait_done(n);
        chk({nm, " done cycle"}, n + 1, 67);
        chk({nm, " shcp edges"}, nedge, 16);
        chk({nm, " bits"}, {16'd0, rx}, {16'd0, exp});
        chk({nm, " stcp pulses"}, npulse - p0, 1);
        chk({nm, " stcp width"}, stcp_hi - h0, 2);
        chk({nm, " oe_n"}, {31'd0, oe_n}, 32'd0);
    endtask

    initial begin
        int n, k, d0, p0;

        // Reset asserted mid-cycle.
        #2 rst_n = 1'b0;
        #1;
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst ds",   {31'd0, ds},   32'd0);
        chk("rst shcp", {31'd0, shcp}, 32'd0);
        chk("rst stcp", {31'd0, stcp}, 32'd0);
        chk("rst oe_n", {31'd0, oe_n}, 32'd1);
        chk_en = 1;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle oe_n", {31'd0, oe_n}, 32'd1);

        run_xfer(16'h1234, 1'b0, 16'h1234, "msb");
        run_xfer(16'h1234, 1'b1, 16'h2C48, "lsb");

        // Start/data changes while busy must be ignored.
        @(negedge clk); #1;
        data = 16'h1234; rvs_en = 1'b0; start = 1'b1;
        nedge = 0; rx = '0; d0 = ndone;
        @(negedge clk); #1;
        start = 1'b0;
        k = 0;
        while (nedge < 5 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("bit5 wait", {31'd0, nedge >= 5}, 32'd1);
        #1;
        data = 16'hFFFF; rvs_en = 1'b1; start = 1'b1;
        repeat (3) @(negedge clk);
        #1 start = 1'b0;
        wait_done(n);
        repeat (10) @(negedge clk);
        chk("busy edges", nedge, 16);
        chk("busy bits", {16'd0, rx}, 32'h1234);
        chk("busy dones", ndone - d0, 1);

        // Back-to-back: start held through the done cycle.
        @(negedge clk); #1;
        data = 16'h00FF; rvs_en = 1'b0; start = 1'b1;
        wait_done(n);
        chk("b2b first done", n, 67);
        @(negedge clk); #1;
        start = 1'b0; nedge = 0; rx = '0;
        wait_done(n);
        chk("b2b gap", n + 1, 67);
        chk("b2b edges", nedge, 16);
        chk("b2b bits", {16'd0, rx}, 32'h00FF);
        chk("b2b oe_n", {31'd0, oe_n}, 32'd0);

        // Reset during bit 7.
        @(negedge clk); #1;
        data = 16'hA5C3; rvs_en = 1'b0; start = 1'b1; nedge = 0;
        @(negedge clk); #1;
        start = 1'b0;
        k = 0;
        while (nedge < 7 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("bit7 wait", {31'd0, nedge >= 7}, 32'd1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid rst busy", {31'd0, busy}, 32'd0);
        chk("mid rst ds",   {31'd0, ds},   32'd0);
        chk("mid rst shcp", {31'd0, shcp}, 32'd0);
        chk("mid rst stcp", {31'd0, stcp}, 32'd0);
        chk("mid rst oe_n", {31'd0, oe_n}, 32'd1);
        d0 = ndone; p0 = npulse;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("mid rst no done", ndone - d0, 0);
        chk("mid rst no stcp", npulse - p0, 0);
        run_xfer(16'h5A0F, 1'b1, 16'hF05A, "post rst");

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
